// File: rtl/four_digit_led_driver_pkg.sv
// Shared constants for the 4-digit 7-segment display driver.
// Segment patterns are {a,b,c,d,e,f,g}, active-low (0 = lit).
package four_digit_led_driver_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       ANODE_OFF = 1'b1;

  // Low two bits of the scan counter.
  localparam logic [1:0] PHASE_LOAD  = 2'b11;
  localparam logic [1:0] PHASE_SHOW1 = 2'b10;
  localparam logic [1:0] PHASE_SHOW0 = 2'b01;

endpackage

// File: rtl/four_digit_led_driver_led_decoder.sv
// Hex nibble to active-low 7-segment pattern {a,b,c,d,e,f,g}.
module led_decoder
  import four_digit_led_driver_pkg::*;
(
  input  logic [3:0] char,
  output logic [6:0] led
);

  // Every nibble value maps to a lit glyph; the case is complete.
  always_comb begin
    unique case (char)
      4'h0: led = SEG_0;
      4'h1: led = SEG_1;
      4'h2: led = SEG_2;
      4'h3: led = SEG_3;
      4'h4: led = SEG_4;
      4'h5: led = SEG_5;
      4'h6: led = SEG_6;
      4'h7: led = SEG_7;
      4'h8: led = SEG_8;
      4'h9: led = SEG_9;
      4'hA: led = SEG_A;
      4'hB: led = SEG_B;
      4'hC: led = SEG_C;
      4'hD: led = SEG_D;
      4'hE: led = SEG_E;
      4'hF: led = SEG_F;
    endcase
  end

endmodule

// File: rtl/four_digit_led_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A 4-bit down counter gives slot (bits 3:2) and phase (bits 1:0). Each slot
// spends one guard cycle loading segments, two cycles with its anode on and
// one blank guard cycle, so segments only move while all anodes are dark.
module four_digit_led_driver
  import four_digit_led_driver_pkg::*;
#(
  parameter logic [3:0] DIGIT3 = 4'h0,
  parameter logic [3:0] DIGIT2 = 4'h1,
  parameter logic [3:0] DIGIT1 = 4'h2,
  parameter logic [3:0] DIGIT0 = 4'h3
) (
  input  logic reset,
  input  logic clk,
  output logic an3,
  output logic an2,
  output logic an1,
  output logic an0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] char_sel;
  logic [6:0] char_led;

  // Select the digit for the slot currently being scanned.
  always_comb begin
    char_sel = DIGIT0;
    unique case (cnt_q[3:2])
      2'd3: char_sel = DIGIT3;
      2'd2: char_sel = DIGIT2;
      2'd1: char_sel = DIGIT1;
      2'd0: char_sel = DIGIT0;
    endcase
  end

  led_decoder u_led_decoder (
    .char (char_sel),
    .led  (char_led)
  );

  // Next counter value; anodes are decoded from it so the registered anodes
  // always match the counter value they sit beside.
  always_comb begin
    cnt_d = cnt_q - 4'd1;
    an_d  = {4{ANODE_OFF}};
    if (cnt_d[1:0] == PHASE_SHOW1 || cnt_d[1:0] == PHASE_SHOW0) begin
      an_d[cnt_d[3:2]] = 1'b0;
    end
    seg_d = seg_q;
    if (cnt_q[1:0] == PHASE_LOAD) begin
      seg_d = char_led;
    end
  end

  // Counter, anode and segment flops; reset blanks the display at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'hF;
      an_q  <= {4{ANODE_OFF}};
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign {an3, an2, an1, an0} = an_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_four_digit_led_driver.sv
// Directed bench for four_digit_led_driver and its led_decoder.
module tb_four_digit_led_driver;

  logic reset, clk;
  logic an3, an2, an1, an0;
  logic a, b, c, d, e, f, g;
  logic [3:0] dchar;
  logic [6:0] dled;

  int n_checks = 0;
  int n_errors = 0;

  four_digit_led_driver dut (
    .reset (reset),
    .clk   (clk),
    .an3   (an3),
    .an2   (an2),
    .an1   (an1),
    .an0   (an0),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g)
  );

  led_decoder u_dec (
    .char (dchar),
    .led  (dled)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-derived frame, index 0 = first sample after reset release.
  logic [3:0] exp_an  [16];
  logic [6:0] exp_seg [16];
  logic [6:0] dec_tab [16];

  logic [3:0] an_v, prev_an;
  logic [6:0] seg_v, prev_seg;
  int overlap, bad_change;
  bit found;

  always_comb an_v  = {an3, an2, an1, an0};
  always_comb seg_v = {a, b, c, d, e, f, g};

  initial begin
    exp_an  = '{4'b0111, 4'b0111, 4'b1111, 4'b1111,
                4'b1011, 4'b1011, 4'b1111, 4'b1111,
                4'b1101, 4'b1101, 4'b1111, 4'b1111,
                4'b1110, 4'b1110, 4'b1111, 4'b1111};
    exp_seg = '{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,
                7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111,
                7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010,
                7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110};
    dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    dchar = 4'h0;

    // Reset held for 100 ns: display dark throughout.
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("rst_an", 32'(an_v), 32'hF);
      check_eq("rst_seg", 32'(seg_v), 32'h7F);
    end
    reset = 1'b0;

    // Two full frames against the hand-built table.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_eq($sformatf("frame_an[%0d]", i), 32'(an_v), 32'(exp_an[i % 16]));
      check_eq($sformatf("frame_seg[%0d]", i), 32'(seg_v), 32'(exp_seg[i % 16]));
    end

    // 10 us run: one anode at most, segments move only after an all-dark cycle.
    overlap = 0;
    bad_change = 0;
    prev_an = an_v;
    prev_seg = seg_v;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ($countones(~an_v) > 1) overlap++;
      if (seg_v != prev_seg && prev_an != 4'hF) bad_change++;
      prev_an = an_v;
      prev_seg = seg_v;
    end
    check_eq("no_overlap", 32'(overlap), 32'd0);
    check_eq("seg_change_dark", 32'(bad_change), 32'd0);

    // Reset in the middle of digit 1's display slot.
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      @(negedge clk);
      if (an_v == 4'b1101) found = 1'b1;
    end
    check_eq("find_an1", 32'(found), 32'd1);
    @(posedge clk);
    #5 reset = 1'b1;
    #1;
    check_eq("async_rst_an", 32'(an_v), 32'hF);
    check_eq("async_rst_seg", 32'(seg_v), 32'h7F);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("resume_an[%0d]", i), 32'(an_v), 32'(exp_an[i]));
      check_eq($sformatf("resume_seg[%0d]", i), 32'(seg_v), 32'(exp_seg[i]));
    end

    // Standalone decoder sweep.
    for (int i = 0; i < 16; i++) begin
      dchar = 4'(i);
      #1;
      check_eq($sformatf("dec[%0h]", i), 32'(dled), 32'(dec_tab[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
